// File: rtl/cla_lookahead_pipe.sv
//============================================================================
// Module      : cla_lookahead_pipe
// Description : Three-stage pipelined carry-lookahead adder/subtractor built
//               from 2-bit groups.
//               Stage 1 registers the bit and group generate/propagate terms.
//               Stage 2 registers every group carry, each from its own
//               lookahead expression.
//               Stage 3 registers the sum, carry-out and signed overflow.
//               A single global enable stalls all three stages together.
// Ports       : clk, rst            clock, synchronous active-high reset
//               in_valid/in_ready   operand handshake (a, b, c_in, sub)
//               out_valid/out_ready result handshake (s, c_out, ovf)
//               a, b                WIDTH-bit operands
//               c_in                carry-in (add) / borrow-in (sub)
//               sub                 0: a+b+c_in, 1: a-b-c_in
//               s                   sum / difference, mod 2^WIDTH
//               c_out               carry-out (sub: 1 = no borrow)
//               ovf                 two's-complement signed overflow
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module cla_lookahead_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf
);

    localparam int GROUPS = WIDTH / 2;

    // Group carry C_n as a flat sum of products over G/P:
    //   C_n = G_(n-1) | P_(n-1)G_(n-2) | ... | P_(n-1)..P_0 c0
    // Each carry gets its own two-level expression instead of waiting on C_(n-1).
    function automatic logic f_carry(input logic [GROUPS-1:0] g_grp,
                                     input logic [GROUPS-1:0] p_grp,
                                     input logic              c0,
                                     input int                n);
        logic sop;
        logic prod;
        sop = 1'b0;
        for (int j = 0; j < n; j++) begin
            prod = g_grp[j];
            for (int m = j + 1; m < n; m++) begin
                prod = prod & p_grp[m];
            end
            sop = sop | prod;
        end
        prod = c0;
        for (int m = 0; m < n; m++) begin
            prod = prod & p_grp[m];
        end
        return sop | prod;
    endfunction

    // ------------------------------------------------------------------
    // Global enable: whole pipe moves unless a held result blocks it
    // ------------------------------------------------------------------
    logic w_en;
    assign w_en     = !out_valid || out_ready;
    assign in_ready = w_en;

    // ------------------------------------------------------------------
    // Stage 1 combinational: operand prep and G/P
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]  w_be;
    logic              w_c0;
    logic [WIDTH-1:0]  w_p;
    logic [WIDTH-1:0]  w_g;
    logic [GROUPS-1:0] w_G;
    logic [GROUPS-1:0] w_P;
    logic [GROUPS-1:0] w_g0;   // low-bit generate of each group, needed for the odd sum bit

    assign w_be = sub ? ~b : b;
    assign w_c0 = c_in ^ sub;
    assign w_p  = a ^ w_be;
    assign w_g  = a & w_be;

    generate
        for (genvar k = 0; k < GROUPS; k++) begin : g_grp_gp
            assign w_G[k]  = w_g[2*k+1] | (w_p[2*k+1] & w_g[2*k]);
            assign w_P[k]  = w_p[2*k+1] & w_p[2*k];
            assign w_g0[k] = w_g[2*k];
        end
    endgenerate

    // Stage 1 registers
    logic              r1_valid;
    logic [WIDTH-1:0]  r1_p;
    logic [GROUPS-1:0] r1_g0;
    logic [GROUPS-1:0] r1_G;
    logic [GROUPS-1:0] r1_P;
    logic              r1_c0;
    logic              r1_amsb;
    logic              r1_bemsb;

    // ------------------------------------------------------------------
    // Stage 2 combinational: lookahead carry unit
    // ------------------------------------------------------------------
    logic [GROUPS:0] w_C;

    assign w_C[0] = r1_c0;

    generate
        for (genvar k = 1; k <= GROUPS; k++) begin : g_lookahead
            assign w_C[k] = f_carry(r1_G, r1_P, r1_c0, k);
        end
    endgenerate

    // Stage 2 registers
    logic              r2_valid;
    logic [WIDTH-1:0]  r2_p;
    logic [GROUPS-1:0] r2_g0;
    logic [GROUPS:0]   r2_C;
    logic              r2_amsb;
    logic              r2_bemsb;

    // ------------------------------------------------------------------
    // Stage 3 combinational: sum and overflow
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_s;
    logic             w_ovf;

    generate
        for (genvar k = 0; k < GROUPS; k++) begin : g_grp_sum
            assign w_s[2*k]   = r2_p[2*k] ^ r2_C[k];
            assign w_s[2*k+1] = r2_p[2*k+1] ^ (r2_g0[k] | (r2_p[2*k] & r2_C[k]));
        end
    endgenerate

    assign w_ovf = (r2_amsb == r2_bemsb) && (w_s[WIDTH-1] != r2_amsb);

    // Output registers
    logic             r_out_valid;
    logic [WIDTH-1:0] r_s;
    logic             r_c_out;
    logic             r_ovf;

    // ------------------------------------------------------------------
    // Control and visible outputs (reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r1_valid    <= 1'b0;
            r2_valid    <= 1'b0;
            r_out_valid <= 1'b0;
            r_s         <= '0;
            r_c_out     <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (w_en) begin
            r1_valid    <= in_valid;
            r2_valid    <= r1_valid;
            r_out_valid <= r2_valid;
            // Bubbles leave the visible result untouched
            if (r2_valid) begin
                r_s     <= w_s;
                r_c_out <= r2_C[GROUPS];
                r_ovf   <= w_ovf;
            end
        end
    end

    // ------------------------------------------------------------------
    // Internal data registers: no reset needed, loaded only with valid
    // data so undriven operands of a bubble never enter the pipe.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_en && in_valid) begin
            r1_p     <= w_p;
            r1_g0    <= w_g0;
            r1_G     <= w_G;
            r1_P     <= w_P;
            r1_c0    <= w_c0;
            r1_amsb  <= a[WIDTH-1];
            r1_bemsb <= w_be[WIDTH-1];
        end
        if (w_en && r1_valid) begin
            r2_p     <= r1_p;
            r2_g0    <= r1_g0;
            r2_C     <= w_C;
            r2_amsb  <= r1_amsb;
            r2_bemsb <= r1_bemsb;
        end
    end

    assign out_valid = r_out_valid;
    assign s         = r_s;
    assign c_out     = r_c_out;
    assign ovf       = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_cla_lookahead_pipe.sv
`timescale 1ns/1ps
`default_nettype none

module tb_cla_lookahead_pipe;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             c_out;
    logic             ovf;

    cla_lookahead_pipe #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .c_in     (c_in),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .s        (s),
        .c_out    (c_out),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic       sb;
        logic [7:0] es;
        logic       ec;
        logic       eo;
    } vec_t;

    int          tests = 0;
    int          fails = 0;
    int          n_out = 0;
    bit          sb_en = 1'b0;
    logic [9:0]  exp_q[$];   // {c_out, s, ovf}

    // Reference: plain integer arithmetic from the operation's definition
    function automatic logic [9:0] model(input logic [7:0] ia, input logic [7:0] ib,
                                         input logic ici, input logic isb);
        int ua, ub, sa, sbv, ci, ur, sr;
        logic c;
        ua  = int'(ia);
        ub  = int'(ib);
        sa  = int'($signed(ia));
        sbv = int'($signed(ib));
        ci  = ici ? 1 : 0;
        if (isb) begin
            ur = ua - ub - ci;
            sr = sa - sbv - ci;
            c  = (ua >= ub + ci);
        end else begin
            ur = ua + ub + ci;
            sr = sa + sbv + ci;
            c  = (ur > 255);
        end
        return {c, ur[7:0], (sr > 127 || sr < -128)};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    // One clock: sample handshakes at negedge, scoreboard, then advance.
    task automatic step(output bit acc);
        logic [9:0] e;
        @(negedge clk);
        acc = in_valid && in_ready && !rst;
        if (rst) begin
            exp_q.delete();
        end else if (sb_en) begin
            if (out_valid && out_ready) begin
                n_out++;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL sb_extra: unexpected result c=%0d s=%02h ovf=%0d", c_out, s, ovf);
                end else begin
                    e = exp_q.pop_front();
                    if ({c_out, s, ovf} !== e) begin
                        fails++;
                        $display("FAIL sb_result#%0d: got c=%0d s=%02h ovf=%0d, expected c=%0d s=%02h ovf=%0d",
                                 n_out, c_out, s, ovf, e[9], e[8:1], e[0]);
                    end
                end
            end
            if (acc) exp_q.push_back(model(a, b, c_in, sub));
        end
        @(posedge clk);
        #1;
    endtask

    // Issue one op with an idle pipe and measure accept-to-out_valid latency
    task automatic one_op(input logic [7:0] ia, input logic [7:0] ib, input logic ici,
                          input logic isb, output int lat);
        bit acc;
        in_valid = 1'b1; a = ia; b = ib; c_in = ici; sub = isb;
        step(acc);
        in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom);
        lat = 1;
        while (!out_valid && lat < 10) begin
            step(acc);
            lat++;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs[10];
        bit   acc;
        int   lat;
        int   issued, got0, stall, acc_cnt, cyc;
        bit   seen, bad;
        logic [7:0] hold_s;
        logic [9:0] e;
        vec_t ops[4];

        vecs[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[1] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[2] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[3] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
        vecs[4] = '{8'h80, 8'h01, 1'b1, 1'b1, 8'h7E, 1'b1, 1'b1};
        vecs[5] = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0};
        vecs[6] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
        vecs[7] = '{8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[8] = '{8'h55, 8'hAA, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[9] = '{8'h7F, 8'hFF, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1};

        ops[0] = '{8'h01, 8'h02, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        ops[1] = '{8'h10, 8'h20, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
        ops[2] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        ops[3] = '{8'h80, 8'h7F, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};

        // ---------------- reset state ----------------
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
        step(acc);
        step(acc);
        rst = 1'b0;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_s", 32'(s), 32'd0);
        chk("reset_c_out", 32'(c_out), 32'd0);
        chk("reset_ovf", 32'(ovf), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);

        // ---------------- directed vector table ----------------
        for (int i = 0; i < 10; i++) begin
            one_op(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].sb, lat);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
            chk($sformatf("vec%0d_result", i), 32'({c_out, s, ovf}),
                32'({vecs[i].ec, vecs[i].es, vecs[i].eo}));
            step(acc);
        end

        // ---------------- back-to-back with output stall ----------------
        sb_en = 1'b1;
        issued = 0; got0 = n_out; stall = 0; seen = 1'b0; hold_s = '0;
        for (int k = 0; k < 30; k++) begin
            in_valid = (issued < 4);
            if (issued < 4) begin
                a = ops[issued].a; b = ops[issued].b;
                c_in = ops[issued].ci; sub = ops[issued].sb;
            end
            out_ready = (stall == 0);
            step(acc);
            if (acc) issued++;
            if (stall > 0) begin
                chk("stall_in_ready", 32'(in_ready), 32'd0);
                chk("stall_s_held", 32'(s), 32'(hold_s));
                stall--;
            end else if (out_valid && !seen) begin
                seen = 1'b1;
                stall = 2;
                hold_s = s;
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("stall_results_count", 32'(n_out - got0), 32'd4);
        chk("stall_queue_empty", 32'(exp_q.size()), 32'd0);
        sb_en = 1'b0;

        // ---------------- reset with ops in flight ----------------
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a = 8'(i + 3); b = 8'(i * 7); c_in = 1'b0; sub = 1'b0;
            step(acc);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        step(acc);
        rst = 1'b0;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_s", 32'(s), 32'd0);
        chk("midrst_flags", 32'({c_out, ovf}), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(acc);
            if (out_valid) bad = 1'b1;
        end
        chk("midrst_no_stale_output", 32'(bad), 32'd0);
        one_op(8'h12, 8'h34, 1'b0, 1'b0, lat);
        chk("postrst_latency", 32'(lat), 32'd3);
        e = model(8'h12, 8'h34, 1'b0, 1'b0);
        chk("postrst_result", 32'({c_out, s, ovf}), 32'(e));
        chk("postrst_result_const", 32'(s), 32'h46);
        step(acc);

        // ---------------- randomized with random backpressure ----------------
        sb_en = 1'b1;
        acc_cnt = 0;
        cyc = 0;
        while (acc_cnt < 10000 && cyc < 60000) begin
            in_valid  = ($urandom_range(0, 4) != 0);
            a         = 8'($urandom);
            b         = 8'($urandom);
            c_in      = 1'($urandom_range(0, 1));
            sub       = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            step(acc);
            if (acc) acc_cnt++;
            cyc++;
        end
        chk("random_ops_accepted", 32'(acc_cnt), 32'd10000);
        in_valid = 1'b0; out_ready = 1'b1;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 20) begin
            step(acc);
            cyc++;
        end
        chk("random_drain_empty", 32'(exp_q.size()), 32'd0);
        step(acc);
        step(acc);
        chk("random_final_out_valid", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
